// File: rtl/word_gen_append.sv
// Candidate generator: emits each popped word unmodified, then once per suffix char in a range.
// Optional macro WORD_GEN_TOTALS_EN adds transfer counters total_count / last_list_count.
module word_gen_append #(
  parameter int unsigned CHAR_BITS    = 7,
  parameter int unsigned WORD_MAX_LEN = 8,
  parameter int unsigned GEN_ID_BITS  = 8,
  localparam int unsigned LEN_BITS    = $clog2(WORD_MAX_LEN + 1),
  localparam int unsigned WORD_BITS   = WORD_MAX_LEN * CHAR_BITS
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [WORD_BITS-1:0]   word_in,
  input  logic [LEN_BITS-1:0]    word_len_in,
  input  logic [15:0]            word_id_in,
  input  logic                   word_list_end_in,
  input  logic                   word_empty,
  output logic                   word_rd_en,
  input  logic                   append_en,
  input  logic [CHAR_BITS-1:0]   char_min,
  input  logic [CHAR_BITS-1:0]   char_max,
`ifdef WORD_GEN_TOTALS_EN
  output logic [31:0]            total_count,
  output logic [31:0]            last_list_count,
`endif
  output logic [WORD_BITS-1:0]   dout,
  output logic [LEN_BITS-1:0]    dout_len,
  output logic [15:0]            dout_word_id,
  output logic [GEN_ID_BITS-1:0] dout_gen_id,
  output logic                   dout_list_end,
  output logic                   dout_valid,
  input  logic                   dout_ready
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] EMIT_ORIG = 2'd1;
  localparam logic [1:0] EMIT_APP  = 2'd2;

  localparam logic [LEN_BITS-1:0] MaxLen = LEN_BITS'(WORD_MAX_LEN);

  logic [1:0]             state_q, state_d;
  logic [WORD_BITS-1:0]   word_q;
  logic [LEN_BITS-1:0]    len_q;
  logic [15:0]            id_q;
  logic                   list_end_q;
  logic                   app_ok_q;
  logic [CHAR_BITS-1:0]   cur_char_q;
  logic [CHAR_BITS-1:0]   char_max_q;
  logic [GEN_ID_BITS-1:0] gen_q;

  logic                   xfer;
  logic                   last_char;
  logic                   app_ok_in;
  logic [WORD_BITS-1:0]   app_word;

  assign word_rd_en = (state_q == IDLE) & ~word_empty & ~reset;
  assign xfer       = dout_valid & dout_ready;
  assign last_char  = (cur_char_q == char_max_q);
  assign app_ok_in  = append_en & (char_min <= char_max) & (word_len_in < MaxLen);

  // Place the suffix char at position len_q; only reachable when len_q < WORD_MAX_LEN.
  always_comb begin
    app_word = word_q;
    for (int unsigned i = 0; i < WORD_MAX_LEN; i++) begin
      if (len_q == LEN_BITS'(i)) begin
        app_word[i*CHAR_BITS +: CHAR_BITS] = cur_char_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (word_rd_en) state_d = EMIT_ORIG;
      end
      EMIT_ORIG: begin
        if (xfer) state_d = app_ok_q ? EMIT_APP : IDLE;
      end
      EMIT_APP: begin
        if (xfer && last_char) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      word_q     <= '0;
      len_q      <= '0;
      id_q       <= '0;
      list_end_q <= 1'b0;
      app_ok_q   <= 1'b0;
      cur_char_q <= '0;
      char_max_q <= '0;
      gen_q      <= '0;
    end else begin
      state_q <= state_d;
      if (word_rd_en) begin
        word_q     <= word_in;
        len_q      <= word_len_in;
        id_q       <= word_id_in;
        list_end_q <= word_list_end_in;
        app_ok_q   <= app_ok_in;
        cur_char_q <= char_min;
        char_max_q <= char_max;
      end else if (xfer && state_q == EMIT_ORIG) begin
        gen_q <= GEN_ID_BITS'(1);
      end else if (xfer && state_q == EMIT_APP && !last_char) begin
        // Compare happens before increment, so char_max = all-ones never wraps.
        cur_char_q <= cur_char_q + CHAR_BITS'(1);
        gen_q      <= gen_q + GEN_ID_BITS'(1);
      end
    end
  end

  always_comb begin
    dout          = '0;
    dout_len      = '0;
    dout_word_id  = '0;
    dout_gen_id   = '0;
    dout_list_end = 1'b0;
    dout_valid    = 1'b0;
    case (state_q)
      EMIT_ORIG: begin
        dout          = word_q;
        dout_len      = len_q;
        dout_word_id  = id_q;
        dout_list_end = list_end_q & ~app_ok_q;
        dout_valid    = 1'b1;
      end
      EMIT_APP: begin
        dout          = app_word;
        dout_len      = len_q + LEN_BITS'(1);
        dout_word_id  = id_q;
        dout_gen_id   = gen_q;
        dout_list_end = list_end_q & last_char;
        dout_valid    = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef WORD_GEN_TOTALS_EN
  logic [31:0] total_q, last_list_q, total_inc;

  assign total_inc       = (total_q == 32'hFFFF_FFFF) ? total_q : total_q + 32'd1;
  assign total_count     = total_q;
  assign last_list_count = last_list_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      total_q     <= '0;
      last_list_q <= '0;
    end else if (xfer) begin
      if (dout_list_end) begin
        last_list_q <= total_inc;
        total_q     <= '0;
      end else begin
        total_q <= total_inc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_word_gen_append.sv
// Directed bench for word_gen_append: hand-computed candidate sequences, stalls and reset.
module tb_word_gen_append;

  logic        CLK = 1'b0;
  logic        reset;
  logic [55:0] word_in;
  logic [3:0]  word_len_in;
  logic [15:0] word_id_in;
  logic        word_list_end_in;
  logic        word_empty;
  logic        word_rd_en;
  logic        append_en;
  logic [6:0]  char_min, char_max;
  logic [55:0] dout;
  logic [3:0]  dout_len;
  logic [15:0] dout_word_id;
  logic [7:0]  dout_gen_id;
  logic        dout_list_end, dout_valid, dout_ready;
`ifdef WORD_GEN_TOTALS_EN
  logic [31:0] total_count, last_list_count;
`endif

  int tests = 0;
  int fails = 0;
  int rd_pulses = 0;
  int p0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (word_rd_en) rd_pulses++;

  word_gen_append dut (
    .CLK(CLK), .reset(reset), .word_in(word_in), .word_len_in(word_len_in),
    .word_id_in(word_id_in), .word_list_end_in(word_list_end_in), .word_empty(word_empty),
    .word_rd_en(word_rd_en), .append_en(append_en), .char_min(char_min), .char_max(char_max),
`ifdef WORD_GEN_TOTALS_EN
    .total_count(total_count), .last_list_count(last_list_count),
`endif
    .dout(dout), .dout_len(dout_len), .dout_word_id(dout_word_id), .dout_gen_id(dout_gen_id),
    .dout_list_end(dout_list_end), .dout_valid(dout_valid), .dout_ready(dout_ready)
  );

  function automatic logic [55:0] pack(input string s);
    logic [55:0] w = '0;
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      w[i*7 +: 7] = b[6:0];
    end
    return w;
  endfunction

  function automatic logic [55:0] app(input logic [55:0] w, input int pos, input logic [6:0] c);
    logic [55:0] r = w;
    r[pos*7 +: 7] = c;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cand(input string tag, input logic [55:0] w, input int len, input logic [15:0] id,
                      input int gen, input bit le);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd1);
    chk({tag, "_dout"}, 64'(dout), 64'(w));
    chk({tag, "_len"}, 64'(dout_len), 64'(len));
    chk({tag, "_id"}, 64'(dout_word_id), 64'(id));
    chk({tag, "_gen"}, 64'(dout_gen_id), 64'(gen));
    chk({tag, "_end"}, 64'(dout_list_end), 64'(le));
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 64'(dout_valid), 64'd0);
    chk({tag, "_dout"}, 64'(dout), 64'd0);
  endtask

  // Offer one word at a negedge; after return we sit at the negedge where the original is valid.
  // Inputs are then scrambled to prove the captured word/config are what get used.
  task automatic present(input string s, input logic [15:0] id, input bit le, input bit en,
                         input logic [6:0] cmin, input logic [6:0] cmax);
    word_in = pack(s); word_len_in = 4'(s.len()); word_id_in = id;
    word_list_end_in = le; append_en = en; char_min = cmin; char_max = cmax;
    word_empty = 1'b0;
    #1 chk({s, "_rd_en"}, 64'(word_rd_en), 64'd1);
    @(negedge CLK);
    word_empty = 1'b1;
    word_in = '1; word_len_in = 4'd1; word_id_in = 16'hFFFF; word_list_end_in = ~le;
    append_en = ~en; char_min = 7'h00; char_max = 7'h01;
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    reset = 1'b1; word_in = '0; word_len_in = '0; word_id_in = '0; word_list_end_in = 1'b0;
    word_empty = 1'b0; append_en = 1'b0; char_min = '0; char_max = '0; dout_ready = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_rd_en", 64'(word_rd_en), 64'd0);
    idle_chk("rst");
    chk("rst_len", 64'(dout_len), 64'd0);
    chk("rst_gen", 64'(dout_gen_id), 64'd0);
    chk("rst_end", 64'(dout_list_end), 64'd0);
`ifdef WORD_GEN_TOTALS_EN
    chk("rst_total", 64'(total_count), 64'd0);
    chk("rst_last", 64'(last_list_count), 64'd0);
`endif
    word_empty = 1'b1; reset = 1'b0;
    step();
    idle_chk("idle");

    // Scenario 1: no appends
    p0 = rd_pulses;
    present("ab", 16'd5, 1'b0, 1'b0, "0", "2");
    cand("s1_orig", pack("ab"), 2, 16'd5, 0, 1'b0);
    chk("s1_rd_en_busy", 64'(word_rd_en), 64'd0);
    step();
    idle_chk("s1_done");
    step();
    idle_chk("s1_idle2");
    chk("s1_pulses", 64'(rd_pulses - p0), 64'd1);

    reset = 1'b1; step(); reset = 1'b0;

    // Scenario 2: "ab" + '0'..'2', list end on last
    p0 = rd_pulses;
    present("ab", 16'd5, 1'b1, 1'b1, "0", "2");
    cand("s2_c0", pack("ab"), 2, 16'd5, 0, 1'b0); step();
    cand("s2_c1", pack("ab0"), 3, 16'd5, 1, 1'b0); step();
    cand("s2_c2", pack("ab1"), 3, 16'd5, 2, 1'b0); step();
    cand("s2_c3", pack("ab2"), 3, 16'd5, 3, 1'b1); step();
    idle_chk("s2_done");
    chk("s2_pulses", 64'(rd_pulses - p0), 64'd1);
`ifdef WORD_GEN_TOTALS_EN
    chk("s2_last", 64'(last_list_count), 64'd4);
    chk("s2_total", 64'(total_count), 64'd0);
`endif

    // Scenario 3: full-length word never gets appends
    present("abcdefgh", 16'd7, 1'b1, 1'b1, "0", "9");
    cand("s3_c0", pack("abcdefgh"), 8, 16'd7, 0, 1'b1); step();
    idle_chk("s3_done");

    // Scenario 4a: empty range
    present("xy", 16'd9, 1'b1, 1'b1, "z", "a");
    cand("s4a_c0", pack("xy"), 2, 16'd9, 0, 1'b1); step();
    idle_chk("s4a_done");

    // Scenario 4b: single-char range
    present("xy", 16'd10, 1'b1, 1'b1, "x", "x");
    cand("s4b_c0", pack("xy"), 2, 16'd10, 0, 1'b0); step();
    cand("s4b_c1", pack("xyx"), 3, 16'd10, 1, 1'b1); step();
    idle_chk("s4b_done");

    // Scenario 5: empty word, top-of-range chars, ready toggling 0/1
    p0 = rd_pulses;
    present("", 16'h1234, 1'b1, 1'b1, 7'h7E, 7'h7F);
    dout_ready = 1'b0;
    cand("s5_c0", 56'd0, 0, 16'h1234, 0, 1'b0); step();
    cand("s5_c0h", 56'd0, 0, 16'h1234, 0, 1'b0);
    dout_ready = 1'b1; step(); dout_ready = 1'b0;
    cand("s5_c1", app(56'd0, 0, 7'h7E), 1, 16'h1234, 1, 1'b0); step();
    cand("s5_c1h", app(56'd0, 0, 7'h7E), 1, 16'h1234, 1, 1'b0);
    dout_ready = 1'b1; step(); dout_ready = 1'b0;
    cand("s5_c2", app(56'd0, 0, 7'h7F), 1, 16'h1234, 2, 1'b1); step();
    cand("s5_c2h", app(56'd0, 0, 7'h7F), 1, 16'h1234, 2, 1'b1);
    dout_ready = 1'b1; step();
    idle_chk("s5_done");
    step();
    idle_chk("s5_nowrap");
    chk("s5_pulses", 64'(rd_pulses - p0), 64'd1);

    // Scenario 6: reset during third candidate
    p0 = rd_pulses;
    present("ab", 16'd3, 1'b1, 1'b1, "0", "5");
    cand("s6_c0", pack("ab"), 2, 16'd3, 0, 1'b0); step();
    cand("s6_c1", pack("ab0"), 3, 16'd3, 1, 1'b0); step();
    cand("s6_c2", pack("ab1"), 3, 16'd3, 2, 1'b0); step();
    cand("s6_c3", pack("ab2"), 3, 16'd3, 3, 1'b0);
    reset = 1'b1; word_empty = 1'b0;
    #1 chk("s6_rd_en_rst", 64'(word_rd_en), 64'd0);
    step();
    reset = 1'b0; word_empty = 1'b1;
    idle_chk("s6_after_rst");
    chk("s6_gen", 64'(dout_gen_id), 64'd0);
    step();
    idle_chk("s6_quiet");
    chk("s6_pulses", 64'(rd_pulses - p0), 64'd1);
`ifdef WORD_GEN_TOTALS_EN
    chk("s6_total", 64'(total_count), 64'd0);
    chk("s6_last", 64'(last_list_count), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/word_gen_append.md
Name: word_gen_append

Overview:
- Sits directly downstream of the word-list stage, in its read-clock domain.
- Pops each stored word and emits a candidate stream toward the hash/crypt units:
  - first the word unmodified;
  - then one candidate per appended suffix character in a configured range.
- Carries word_id through and flags the last candidate of the last word in a list.

Parameters:
CHAR_BITS, 7, bits per character
WORD_MAX_LEN, 8, max characters per word and per candidate
GEN_ID_BITS, 8, width of per-word candidate index (must be >= CHAR_BITS+1)

Ports:
CLK  in  1  clock
reset  in  1  synchronous active-high reset
word_in  in  WORD_MAX_LEN*CHAR_BITS  upstream word; char i at bits [(i+1)*CHAR_BITS-1 -: CHAR_BITS], unused chars zero
word_len_in  in  `MSB(WORD_MAX_LEN)+1  upstream word length
word_id_in  in  16  upstream word id
word_list_end_in  in  1  word is last of its list
word_empty  in  1  upstream empty; inputs valid (first-word-fall-through) while low
word_rd_en  out  1  pop upstream word
append_en  in  1  config: generate appended candidates
char_min  in  CHAR_BITS  config: first suffix char
char_max  in  CHAR_BITS  config: last suffix char (inclusive)
dout  out  WORD_MAX_LEN*CHAR_BITS  candidate, same packing as word_in
dout_len  out  `MSB(WORD_MAX_LEN)+1  candidate length
dout_word_id  out  16  originating word id
dout_gen_id  out  GEN_ID_BITS  candidate index within word; 0 = original
dout_list_end  out  1  last candidate of a list-ending word
dout_valid  out  1  candidate valid
dout_ready  in  1  downstream accepts; transfer = dout_valid & dout_ready

Behaviour:
- Clock and reset: single clock CLK; reset is synchronous, active-high.
- Reset values: all outputs 0 (dout, dout_len, dout_word_id, dout_gen_id, dout_list_end, dout_valid, word_rd_en); FSM -> IDLE.
- Reset mid-operation: the current word is discarded, no further candidates are emitted, and the upstream word is not re-popped.
- word_rd_en is combinational = (state==IDLE) & ~word_empty & ~reset.
- Capture on pop: word_in, word_len_in, word_id_in, word_list_end_in and the config inputs (append_en, char_min, char_max) are latched. Config changes mid-word have no effect.
- Derived flag app_ok = append_en & (char_min <= char_max) & (word_len < WORD_MAX_LEN).
- FSM states:
  - IDLE: on pop -> EMIT_ORIG. First candidate is valid on the cycle after the pop (latency 1).
  - EMIT_ORIG:
    - dout = word, dout_len = word_len, gen_id = 0, dout_valid = 1.
    - dout_list_end = word_list_end & ~app_ok.
    - On transfer: if app_ok -> EMIT_APP with cur_char = char_min; else -> IDLE.
  - EMIT_APP:
    - dout = word with char position word_len set to cur_char; dout_len = word_len+1.
    - gen_id increments by 1 per candidate (1..N).
    - dout_list_end = word_list_end & (cur_char == char_max).
    - On transfer: if cur_char == char_max -> IDLE; else cur_char+1.
- Throughput: one candidate per cycle while dout_ready=1, plus one bubble cycle (IDLE) per word.
- Backpressure: when dout_valid & ~dout_ready, all dout* outputs hold stable.
- Arithmetic: cur_char compare is done before increment, so char_max = 2^CHAR_BITS-1 terminates without wrap. gen_id = cur_char-char_min+1 and never exceeds 2^CHAR_BITS.
- Empty words (word_len_in = 0) are passed through as-is: the original candidate has len 0; the appended candidates are single characters.

Optional Feature:
- Macro WORD_GEN_TOTALS_EN.
- When defined: adds output total_count [31:0]. It increments on every transfer, saturates at 32'hFFFFFFFF, and resets to 0. It also clears on the transfer whose dout_list_end=1, after that transfer is counted into output last_list_count [31:0] (reset 0).
- When undefined: neither port exists, and the counters consume no logic.

Test Plan:
- Word "ab" (len 2, id 5, end 0), append_en=0, dout_ready=1 -> single candidate "ab", len 2, gen_id 0, list_end 0; FSM back in IDLE; word_rd_en pulses exactly once.
- Same word, append_en=1, char_min='0', char_max='2' -> "ab", "ab0", "ab1", "ab2"; gen_id 0..3; lens 2,3,3,3; 4 consecutive valid cycles.
- 8-char word with word_list_end=1, append enabled -> one candidate, len 8, list_end=1, no appends.
- char_min='z', char_max='a', word_list_end=1 -> one candidate with list_end=1; with char_min=char_max='x' -> 2 candidates, list_end only on "...x".
- char_min=7'h7E, char_max=7'h7F -> exactly 3 candidates, no wrap. Toggle dout_ready 1/0 every cycle -> outputs stable while stalled, no drops or duplicates.
- Assert reset during EMIT_APP of 3rd candidate -> next cycle dout_valid=0, FSM IDLE. With WORD_GEN_TOTALS_EN, total_count=0 after reset, and last_list_count=4 after the second scenario with list_end set.
